// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared states, block constants and frame length for the AES SPI frame interface
package aes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_LOAD,
    ST_WAIT,
    ST_HOLD
  } state_t;

  localparam int DIR_BITS = 8;
  localparam int BLK_BITS = 128;

  // Total bits in one inbound frame: direction byte, key, message block.
  function automatic int frame_bits(input int k);
    return DIR_BITS + k + BLK_BITS;
  endfunction

endpackage

// File: rtl/aes_sync2.sv
// rtl/aes_sync2.sv - two-flop synchronizer with registered edge detect
module aes_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic s3;

  // Two metastability flops, plus one delay flop used only for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign q    = s2;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

endmodule

// File: rtl/aes_frame_if.sv
// rtl/aes_frame_if.sv - SPI frame front end for an AES core; AES_FRAME_STATUS_EN prepends a status byte to r_miso
module aes_frame_if
  import aes_pkg::*;
#(
  parameter int K   = 192,
  parameter int INV = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                r_sclk,
  input  logic                r_mosi,
  input  logic                r_ce,
  output logic                r_miso,
  output logic [K-1:0]        key,
  output logic [BLK_BITS-1:0] message,
  output logic                dir,
  output logic                start,
  input  logic                done,
  input  logic [BLK_BITS-1:0] translated,
  output logic                frame_err,
  output logic                overrun
);

  localparam int N  = frame_bits(K);
  localparam int CW = $clog2(N + 2);

  if (!(K == 128 || K == 192 || K == 256)) begin : g_bad_k
    $error("aes_frame_if: K must be 128, 192 or 256");
  end
  if (!(INV == 0 || INV == 1 || INV == 2)) begin : g_bad_inv
    $error("aes_frame_if: INV must be 0, 1 or 2");
  end

`ifdef AES_FRAME_STATUS_EN
  localparam int OUT_W = BLK_BITS + 8;
`else
  localparam int OUT_W = BLK_BITS;
`endif

  logic sclk_lvl_unused;
  logic sclk_rise;
  logic sclk_fall;
  logic mosi_q;
  logic mosi_rise_unused;
  logic mosi_fall_unused;
  logic ce_lvl;
  logic ce_rise;
  logic ce_fall;

  aes_sync2 u_sync_sclk (
    .clk  (clk),
    .reset(reset),
    .d    (r_sclk),
    .q    (sclk_lvl_unused),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  aes_sync2 u_sync_mosi (
    .clk  (clk),
    .reset(reset),
    .d    (r_mosi),
    .q    (mosi_q),
    .rise (mosi_rise_unused),
    .fall (mosi_fall_unused)
  );

  aes_sync2 u_sync_ce (
    .clk  (clk),
    .reset(reset),
    .d    (r_ce),
    .q    (ce_lvl),
    .rise (ce_rise),
    .fall (ce_fall)
  );

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [N-1:0]        sr;
  logic [BLK_BITS-1:0] result;
  logic [OUT_W-1:0]    out_sr;
  logic                wait_rx;
  logic [OUT_W-1:0]    out_res;
  logic [OUT_W-1:0]    out_xlt;

`ifdef AES_FRAME_STATUS_EN
  logic [7:0] status_byte;
  assign status_byte = {6'b0, overrun, frame_err};
  assign out_res     = {status_byte, result};
  assign out_xlt     = {status_byte, translated};
`else
  assign out_res = result;
  assign out_xlt = translated;
`endif

  // The outbound register's MSB is the line; zeros shift in behind the payload.
  assign r_miso = out_sr[OUT_W-1];

  // Frame receive / launch / capture state machine with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      sr        <= '0;
      result    <= '0;
      out_sr    <= '0;
      wait_rx   <= 1'b0;
      key       <= '0;
      message   <= '0;
      dir       <= 1'b0;
      start     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ce_rise) begin
            state  <= ST_SHIFT;
            cnt    <= '0;
            out_sr <= out_res;
          end
        end
        ST_SHIFT: begin
          if (ce_fall) begin
            if (cnt == CW'(N)) begin
              state <= ST_LOAD;
            end else begin
              state     <= ST_IDLE;
              frame_err <= 1'b1;
            end
          end else begin
            if (sclk_rise) begin
              sr <= {sr[N-2:0], mosi_q};
              if (cnt != CW'(N + 1)) cnt <= cnt + 1'b1;
            end
            if (sclk_fall) out_sr <= out_sr << 1;
          end
        end
        ST_LOAD: begin
          // A new frame already under way holds the launch until ce drops.
          if (!ce_lvl) begin
            key       <= sr[BLK_BITS +: K];
            message   <= sr[BLK_BITS-1:0];
            if (INV == 0)      dir <= 1'b0;
            else if (INV == 2) dir <= 1'b1;
            else               dir <= sr[N-DIR_BITS];
            start     <= 1'b1;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (done && !wait_rx) begin
            result <= translated;
            if (ce_rise) begin
              state  <= ST_SHIFT;
              cnt    <= '0;
              out_sr <= out_xlt;
            end else begin
              state <= ST_HOLD;
            end
          end else if (wait_rx) begin
            // Core still busy: this frame is clocked in only to be dropped.
            if (ce_fall) begin
              wait_rx <= 1'b0;
              overrun <= 1'b1;
            end else if (sclk_rise) begin
              sr <= {sr[N-2:0], mosi_q};
              if (cnt != CW'(N + 1)) cnt <= cnt + 1'b1;
            end
          end else if (ce_rise) begin
            wait_rx <= 1'b1;
            cnt     <= '0;
          end
        end
        ST_HOLD: begin
          if (ce_rise) begin
            state  <= ST_SHIFT;
            cnt    <= '0;
            out_sr <= out_res;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_frame_if.sv
// tb/tb_aes_frame_if.sv - directed bench for aes_frame_if (K=128/INV=1 and K=256/INV=2)
module tb_aes_frame_if;

`ifdef AES_FRAME_STATUS_EN
  localparam int OUT_W = 136;
`else
  localparam int OUT_W = 128;
`endif

  localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] MSG1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY2 = 128'hfedcba98765432100123456789abcdef;
  localparam logic [127:0] MSG2 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  localparam logic [127:0] RES  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] KEYB = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic r_sclk = 1'b0;
  logic r_mosi = 1'b0;
  logic ce_a = 1'b0;
  logic ce_b = 1'b0;
  logic done_a = 1'b0;
  logic done_b = 1'b0;
  logic [127:0] translated_a = '0;
  logic [127:0] translated_b = '0;

  logic         miso_a, dir_a, start_a, frame_err_a, overrun_a;
  logic [127:0] key_a, message_a;
  logic         miso_b, dir_b, start_b, frame_err_b, overrun_b;
  logic [255:0] key_b;
  logic [127:0] message_b;

  int n_checks = 0;
  int n_fail = 0;
  int starts_a = 0;
  int starts_b = 0;
  logic [391:0] rx_all;
  logic [391:0] f;
  logic [391:0] tail;
  logic [OUT_W-1:0] exp_out;
  logic [OUT_W-1:0] got_out;

  aes_frame_if #(.K(128), .INV(1)) dut (
    .clk(clk), .reset(reset), .r_sclk(r_sclk), .r_mosi(r_mosi), .r_ce(ce_a),
    .r_miso(miso_a), .key(key_a), .message(message_a), .dir(dir_a), .start(start_a),
    .done(done_a), .translated(translated_a), .frame_err(frame_err_a), .overrun(overrun_a)
  );

  aes_frame_if #(.K(256), .INV(2)) dut256 (
    .clk(clk), .reset(reset), .r_sclk(r_sclk), .r_mosi(r_mosi), .r_ce(ce_b),
    .r_miso(miso_b), .key(key_b), .message(message_b), .dir(dir_b), .start(start_b),
    .done(done_b), .translated(translated_b), .frame_err(frame_err_b), .overrun(overrun_b)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (start_a) starts_a++;
    if (start_b) starts_b++;
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Mode-0 master: bit on mosi, miso sampled just before each sclk rise.
  task automatic spi_frame(input logic [391:0] data, input int n, input bit sel_b, input int stop_at);
    rx_all = '0;
    if (sel_b) ce_b = 1'b1; else ce_a = 1'b1;
    clks(4);
    for (int i = n - 1; i >= 0; i--) begin
      if (n - 1 - i == stop_at) return;
      r_mosi = data[i];
      clks(8);
      rx_all = {rx_all[390:0], (sel_b ? miso_b : miso_a)};
      r_sclk = 1'b1;
      clks(8);
      r_sclk = 1'b0;
    end
    clks(8);
    ce_a = 1'b0;
    ce_b = 1'b0;
    clks(12);
  endtask

  initial begin
    clks(3);
    check("rst_key", key_a, 0);
    check("rst_message", message_a, 0);
    check("rst_flags", {dir_a, start_a, miso_a, frame_err_a, overrun_a}, 0);
    reset = 1'b0;
    clks(3);

    f = {128'b0, 8'h00, KEY1, MSG1};
    spi_frame(f, 264, 1'b0, -1);
    check("f1_starts", starts_a, 1);
    check("f1_key", key_a, KEY1);
    check("f1_message", message_a, MSG1);
    check("f1_dir", dir_a, 0);

    translated_a = RES;
    done_a = 1'b1;
    clks(4);
    done_a = 1'b0;

    f = {128'b0, 8'h01, KEY2, MSG2};
    spi_frame(f, 264, 1'b0, -1);
`ifdef AES_FRAME_STATUS_EN
    exp_out = {8'h00, RES};
`else
    exp_out = RES;
`endif
    got_out = rx_all[263 -: OUT_W];
    check("f2_miso_result", got_out, exp_out);
    tail = rx_all & ((392'b1 << (264 - OUT_W)) - 392'b1);
    check("f2_miso_tail_zero", |tail, 0);
    check("f2_starts", starts_a, 2);
    check("f2_key", key_a, KEY2);
    check("f2_dir", dir_a, 1);

    f = {128'b0, 8'h00, KEY1, MSG1};
    spi_frame(f, 264, 1'b0, -1);
    check("f3_overrun", overrun_a, 1);
    check("f3_key_kept", key_a, KEY2);
    check("f3_starts", starts_a, 2);

    done_a = 1'b1;
    clks(4);
    done_a = 1'b0;

    f = 392'(100'h123456789abcdef0123456789);
    spi_frame(f, 100, 1'b0, -1);
    check("f4_frame_err", frame_err_a, 1);
    check("f4_starts", starts_a, 2);
    check("f4_overrun_sticky", overrun_a, 1);

    f = {128'b0, 8'h00, KEY1, MSG1};
    spi_frame(f, 264, 1'b0, -1);
    check("f5_frame_err_clr", frame_err_a, 0);
    check("f5_overrun_clr", overrun_a, 0);
    check("f5_starts", starts_a, 3);
    check("f5_key", key_a, KEY1);

    done_a = 1'b1;
    clks(4);
    done_a = 1'b0;

    spi_frame(f, 264, 1'b0, 50);
    reset = 1'b1;
    #1;
    check("rst50_key", key_a, 0);
    check("rst50_message", message_a, 0);
    check("rst50_flags", {dir_a, start_a, miso_a, frame_err_a, overrun_a}, 0);
    clks(2);
    reset = 1'b0;
    clks(10);
    ce_a = 1'b0;
    r_mosi = 1'b0;
    clks(20);
    check("rst50_no_start", starts_a, 3);
    check("rst50_key_after", key_a, 0);

    f = {8'h00, KEYB, MSG1};
    spi_frame(f, 392, 1'b1, -1);
    check("k256_starts", starts_b, 1);
    check("k256_dir_forced", dir_b, 1);
    check("k256_key", key_b, KEYB);
    check("k256_message", message_b, MSG1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
